// File: rtl/tree_msg_encoder.sv
// Serializes flat leaf records into a CLOSE/OPEN/LEAF/END token stream for the
// hierarchical message tree. A stack holds the ids of the open containers. Each
// record closes levels back to the common prefix, opens the new levels, emits the
// leaf and, on the last record, closes everything and emits END.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         record handshake
//   in_path/in_depth          container ids (level l at [l*NODE_ID_W +: NODE_ID_W]), depth
//   in_leaf_id/in_data        leaf id and payload
//   in_last                   final record: close all levels and emit END after the leaf
//   out_valid/out_ready       token handshake
//   out_kind                  0=OPEN, 1=LEAF, 2=CLOSE, 3=END
//   out_node_id/out_level     token node id and tree level
//   out_data                  payload for LEAF, 0 otherwise
//   cur_depth                 number of open containers
//   err_null                  one-cycle pulse when a record is dropped
module tree_msg_encoder #(
    parameter int unsigned NUM_MSG_HIERARCHY = 4,
    parameter int unsigned NODE_ID_W         = 16,
    parameter int unsigned DATA_W            = 32,
    parameter int unsigned DEPTH_W           = $clog2(NUM_MSG_HIERARCHY + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUM_MSG_HIERARCHY*NODE_ID_W-1:0] in_path,
    input  logic [DEPTH_W-1:0]                     in_depth,
    input  logic [NODE_ID_W-1:0]                   in_leaf_id,
    input  logic [DATA_W-1:0]                      in_data,
    input  logic                                   in_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [1:0]                             out_kind,
    output logic [NODE_ID_W-1:0]                   out_node_id,
    output logic [DEPTH_W-1:0]                     out_level,
    output logic [DATA_W-1:0]                      out_data,
    output logic [DEPTH_W-1:0]                     cur_depth,
    output logic                                   err_null
);

    localparam int unsigned IdxW = (NUM_MSG_HIERARCHY > 1) ? $clog2(NUM_MSG_HIERARCHY) : 1;
    localparam logic [DEPTH_W-1:0] MaxDepth = DEPTH_W'(NUM_MSG_HIERARCHY);

    localparam logic [1:0] KindOpen  = 2'd0;
    localparam logic [1:0] KindLeaf  = 2'd1;
    localparam logic [1:0] KindClose = 2'd2;
    localparam logic [1:0] KindEnd   = 2'd3;

    typedef logic [NUM_MSG_HIERARCHY-1:0][NODE_ID_W-1:0] path_t;

    typedef enum logic [2:0] {
        StIdle, StClose, StOpen, StLeaf, StCloseAll, StEnd
    } state_e;

    state_e               state_q, state_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    path_t                stack_q, stack_d;
    path_t                rec_path_q, rec_path_d;
    logic [DEPTH_W-1:0]   rec_depth_q, rec_depth_d;
    logic [NODE_ID_W-1:0] rec_leaf_q, rec_leaf_d;
    logic [DATA_W-1:0]    rec_data_q, rec_data_d;
    logic                 rec_last_q, rec_last_d;
    logic [DEPTH_W-1:0]   prefix_q, prefix_d;
    logic                 err_d;

    path_t                in_path_arr;
    logic [DEPTH_W-1:0]   prefix;
    logic                 match;
    logic                 path_null;
    logic                 drop;
    logic                 hs;

    logic                 tok_valid;
    logic [1:0]           tok_kind;
    logic [NODE_ID_W-1:0] tok_id;
    logic [DEPTH_W-1:0]   tok_level;
    logic [DATA_W-1:0]    tok_data;
    logic [DEPTH_W-1:0]   close_lvl;

    assign in_path_arr = in_path;
    assign in_ready    = (state_q == StIdle) && !rst;
    assign cur_depth   = depth_q;
    assign hs          = out_valid && out_ready;

    // Common prefix of the open stack and the incoming path, plus null-id scan.
    always_comb begin
        prefix    = '0;
        match     = 1'b1;
        path_null = 1'b0;
        for (int l = 0; l < NUM_MSG_HIERARCHY; l++) begin
            if (match && (DEPTH_W'(l) < depth_q) && (DEPTH_W'(l) < in_depth) &&
                (stack_q[l] == in_path_arr[l])) begin
                prefix = prefix + 1'b1;
            end else begin
                match = 1'b0;
            end
            if ((DEPTH_W'(l) < in_depth) && (in_path_arr[l] == '0)) begin
                path_null = 1'b1;
            end
        end
        drop = path_null || (in_leaf_id == '0) || (in_depth > MaxDepth);
    end

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        stack_d     = stack_q;
        rec_path_d  = rec_path_q;
        rec_depth_d = rec_depth_q;
        rec_leaf_d  = rec_leaf_q;
        rec_data_d  = rec_data_q;
        rec_last_d  = rec_last_q;
        prefix_d    = prefix_q;
        err_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (drop) begin
                        err_d = 1'b1;
                    end else begin
                        rec_path_d  = in_path_arr;
                        rec_depth_d = in_depth;
                        rec_leaf_d  = in_leaf_id;
                        rec_data_d  = in_data;
                        rec_last_d  = in_last;
                        prefix_d    = prefix;
                        if (depth_q > prefix)       state_d = StClose;
                        else if (in_depth > prefix) state_d = StOpen;
                        else                        state_d = StLeaf;
                    end
                end
            end
            StClose: begin
                if (hs) begin
                    depth_d = depth_q - 1'b1;
                    if (depth_d == prefix_q) begin
                        state_d = (rec_depth_q > prefix_q) ? StOpen : StLeaf;
                    end
                end
            end
            StOpen: begin
                if (hs) begin
                    stack_d[depth_q[IdxW-1:0]] = rec_path_q[depth_q[IdxW-1:0]];
                    depth_d = depth_q + 1'b1;
                    if (depth_d == rec_depth_q) state_d = StLeaf;
                end
            end
            StLeaf: begin
                if (hs) begin
                    if (!rec_last_q)          state_d = StIdle;
                    else if (depth_q != '0)   state_d = StCloseAll;
                    else                      state_d = StEnd;
                end
            end
            StCloseAll: begin
                if (hs) begin
                    depth_d = depth_q - 1'b1;
                    if (depth_d == '0) state_d = StEnd;
                end
            end
            StEnd: begin
                if (hs) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Token for the state being entered, built from next-state values. While the
    // output is stalled nothing changes, so the registered token holds by itself.
    always_comb begin
        tok_valid = 1'b0;
        tok_kind  = KindOpen;
        tok_id    = '0;
        tok_level = '0;
        tok_data  = '0;
        close_lvl = depth_d - 1'b1;
        case (state_d)
            StClose, StCloseAll: begin
                tok_valid = 1'b1;
                tok_kind  = KindClose;
                tok_id    = stack_d[close_lvl[IdxW-1:0]];
                tok_level = close_lvl;
            end
            StOpen: begin
                tok_valid = 1'b1;
                tok_kind  = KindOpen;
                tok_id    = rec_path_d[depth_d[IdxW-1:0]];
                tok_level = depth_d;
            end
            StLeaf: begin
                tok_valid = 1'b1;
                tok_kind  = KindLeaf;
                tok_id    = rec_leaf_d;
                tok_level = rec_depth_d;
                tok_data  = rec_data_d;
            end
            StEnd: begin
                tok_valid = 1'b1;
                tok_kind  = KindEnd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            depth_q     <= '0;
            stack_q     <= '0;
            rec_path_q  <= '0;
            rec_depth_q <= '0;
            rec_leaf_q  <= '0;
            rec_data_q  <= '0;
            rec_last_q  <= 1'b0;
            prefix_q    <= '0;
            err_null    <= 1'b0;
            out_valid   <= 1'b0;
            out_kind    <= '0;
            out_node_id <= '0;
            out_level   <= '0;
            out_data    <= '0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            stack_q     <= stack_d;
            rec_path_q  <= rec_path_d;
            rec_depth_q <= rec_depth_d;
            rec_leaf_q  <= rec_leaf_d;
            rec_data_q  <= rec_data_d;
            rec_last_q  <= rec_last_d;
            prefix_q    <= prefix_d;
            err_null    <= err_d;
            out_valid   <= tok_valid;
            out_kind    <= tok_kind;
            out_node_id <= tok_id;
            out_level   <= tok_level;
            out_data    <= tok_data;
        end
    end

endmodule

// File: tb/tb_tree_msg_encoder.sv
// Directed bench for tree_msg_encoder: hand-computed token sequences per record.
module tb_tree_msg_encoder;

    localparam int unsigned NH   = 4;
    localparam int unsigned IDW  = 16;
    localparam int unsigned DW   = 32;
    localparam int unsigned DEPW = 3;

    localparam logic [1:0] KOpen  = 2'd0;
    localparam logic [1:0] KLeaf  = 2'd1;
    localparam logic [1:0] KClose = 2'd2;
    localparam logic [1:0] KEnd   = 2'd3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [NH*IDW-1:0] in_path;
    logic [DEPW-1:0]   in_depth;
    logic [IDW-1:0]    in_leaf_id;
    logic [DW-1:0]     in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_kind;
    logic [IDW-1:0]    out_node_id;
    logic [DEPW-1:0]   out_level;
    logic [DW-1:0]     out_data;
    logic [DEPW-1:0]   cur_depth;
    logic              err_null;

    int n_checks = 0;
    int n_errors = 0;

    tree_msg_encoder #(
        .NUM_MSG_HIERARCHY(NH),
        .NODE_ID_W        (IDW),
        .DATA_W           (DW),
        .DEPTH_W          (DEPW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_path    (in_path),
        .in_depth   (in_depth),
        .in_leaf_id (in_leaf_id),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_kind   (out_kind),
        .out_node_id(out_node_id),
        .out_level  (out_level),
        .out_data   (out_data),
        .cur_depth  (cur_depth),
        .err_null   (err_null)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] tok(input logic [1:0] k, input logic [IDW-1:0] id,
                                        input logic [DEPW-1:0] lvl, input logic [DW-1:0] d);
        return {11'b0, k, id, lvl, d};
    endfunction

    function automatic logic [63:0] mk_path(input logic [IDW-1:0] p0, input logic [IDW-1:0] p1,
                                            input logic [IDW-1:0] p2, input logic [IDW-1:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [63:0] path, input logic [DEPW-1:0] depth,
                        input logic [IDW-1:0] leaf, input logic [DW-1:0] data,
                        input logic last);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send in_ready timeout", {63'b0, in_ready}, 64'd1);
        in_valid   = 1'b1;
        in_path    = path;
        in_depth   = depth;
        in_leaf_id = leaf;
        in_data    = data;
        in_last    = last;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a token, compare it, and let it handshake with out_ready=1.
    task automatic expect_tok(input string tag, input logic [63:0] exp);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        check({tag, " valid"}, {63'b0, out_valid}, 64'd1);
        check(tag, {11'b0, out_kind, out_node_id, out_level, out_data}, exp);
        @(negedge clk);
    endtask

    logic [63:0] stall_exp[7];
    int          idx;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_path   = '0;
        in_depth  = '0;
        in_leaf_id = '0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst out_valid", {63'b0, out_valid}, 64'd0);
        check("rst cur_depth", {61'b0, cur_depth}, 64'd0);
        check("rst err_null", {63'b0, err_null}, 64'd0);
        check("rst in_ready", {63'b0, in_ready}, 64'd0);
        check("rst out_fields", {11'b0, out_kind, out_node_id, out_level, out_data}, 64'd0);
        rst = 1'b0;
        #1;
        check("post rst in_ready", {63'b0, in_ready}, 64'd1);

        // Open two levels from empty.
        send(mk_path(5, 7, 0, 0), 3'd2, 16'd9, 32'hA5, 1'b0);
        check("t1 latency", {63'b0, out_valid}, 64'd1);
        expect_tok("t1 open5", tok(KOpen, 5, 0, 0));
        expect_tok("t1 open7", tok(KOpen, 7, 1, 0));
        expect_tok("t1 leaf9", tok(KLeaf, 9, 2, 32'hA5));
        check("t1 cur_depth", {61'b0, cur_depth}, 64'd2);
        check("t1 in_ready", {63'b0, in_ready}, 64'd1);

        // Sibling switch at level 1, last record.
        send(mk_path(5, 8, 0, 0), 3'd2, 16'd3, 32'h11, 1'b1);
        expect_tok("t2 close7", tok(KClose, 7, 1, 0));
        expect_tok("t2 open8", tok(KOpen, 8, 1, 0));
        expect_tok("t2 leaf3", tok(KLeaf, 3, 2, 32'h11));
        expect_tok("t2 close8", tok(KClose, 8, 1, 0));
        expect_tok("t2 close5", tok(KClose, 5, 0, 0));
        expect_tok("t2 end", tok(KEnd, 0, 0, 0));
        check("t2 cur_depth", {61'b0, cur_depth}, 64'd0);

        // Same path twice.
        send(mk_path(4, 0, 0, 0), 3'd1, 16'd1, 32'h21, 1'b0);
        expect_tok("t3 open4", tok(KOpen, 4, 0, 0));
        expect_tok("t3 leaf1", tok(KLeaf, 1, 1, 32'h21));
        send(mk_path(4, 0, 0, 0), 3'd1, 16'd2, 32'h22, 1'b0);
        expect_tok("t3 leaf2", tok(KLeaf, 2, 1, 32'h22));
        check("t3 only leaf", {63'b0, out_valid}, 64'd0);
        check("t3 cur_depth", {61'b0, cur_depth}, 64'd1);

        // Dropped records: null path id, null leaf, depth too large.
        send(mk_path(5, 0, 0, 0), 3'd2, 16'd6, 32'h0, 1'b0);
        check("e1 err pulse", {63'b0, err_null}, 64'd1);
        check("e1 no token", {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        check("e1 err clear", {63'b0, err_null}, 64'd0);
        check("e1 no token later", {63'b0, out_valid}, 64'd0);
        send(mk_path(4, 0, 0, 0), 3'd1, 16'd0, 32'h0, 1'b0);
        check("e2 err pulse", {63'b0, err_null}, 64'd1);
        check("e2 no token", {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        send(mk_path(1, 2, 3, 4), 3'd5, 16'd6, 32'h0, 1'b0);
        check("e3 err pulse", {63'b0, err_null}, 64'd1);
        check("e3 no token", {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        check("e cur_depth", {61'b0, cur_depth}, 64'd1);
        // Stack still [4]: only a LEAF follows.
        send(mk_path(4, 0, 0, 0), 3'd1, 16'd7, 32'h77, 1'b0);
        expect_tok("e leaf7", tok(KLeaf, 7, 1, 32'h77));
        check("e only leaf", {63'b0, out_valid}, 64'd0);

        // Backpressure with random out_ready.
        stall_exp[0] = tok(KOpen, 9, 1, 0);
        stall_exp[1] = tok(KOpen, 10, 2, 0);
        stall_exp[2] = tok(KLeaf, 11, 3, 32'hBEEF);
        stall_exp[3] = tok(KClose, 10, 2, 0);
        stall_exp[4] = tok(KClose, 9, 1, 0);
        stall_exp[5] = tok(KClose, 4, 0, 0);
        stall_exp[6] = tok(KEnd, 0, 0, 0);
        out_ready = 1'b0;
        send(mk_path(4, 9, 10, 0), 3'd3, 16'd11, 32'hBEEF, 1'b1);
        idx = 0;
        for (int c = 0; c < 300 && idx < 7; c++) begin
            if (out_valid) begin
                check("stall tok", {11'b0, out_kind, out_node_id, out_level, out_data},
                      stall_exp[idx]);
                check("stall in_ready", {63'b0, in_ready}, 64'd0);
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) idx++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("stall count", 64'(idx), 64'd7);
        check("stall done", {63'b0, out_valid}, 64'd0);
        check("stall cur_depth", {61'b0, cur_depth}, 64'd0);

        // Reset in the middle of an OPEN with one level open.
        send(mk_path(1, 0, 0, 0), 3'd1, 16'd2, 32'h0, 1'b0);
        expect_tok("r open1", tok(KOpen, 1, 0, 0));
        expect_tok("r leaf2", tok(KLeaf, 2, 1, 0));
        out_ready = 1'b0;
        send(mk_path(1, 3, 6, 0), 3'd3, 16'd4, 32'h0, 1'b0);
        check("r stalled open3", {11'b0, out_kind, out_node_id, out_level, out_data},
              tok(KOpen, 3, 1, 0));
        check("r depth before", {61'b0, cur_depth}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("r out_valid", {63'b0, out_valid}, 64'd0);
        check("r cur_depth", {61'b0, cur_depth}, 64'd0);
        check("r in_ready", {63'b0, in_ready}, 64'd1);
        out_ready = 1'b1;
        send(mk_path(1, 3, 0, 0), 3'd2, 16'd5, 32'h55, 1'b0);
        expect_tok("r2 open1", tok(KOpen, 1, 0, 0));
        expect_tok("r2 open3", tok(KOpen, 3, 1, 0));
        expect_tok("r2 leaf5", tok(KLeaf, 5, 2, 32'h55));

        // Depth 0 record closes everything, leaf at root, then END.
        send(mk_path(0, 0, 0, 0), 3'd0, 16'd8, 32'h88, 1'b1);
        expect_tok("d0 close3", tok(KClose, 3, 1, 0));
        expect_tok("d0 close1", tok(KClose, 1, 0, 0));
        expect_tok("d0 leaf8", tok(KLeaf, 8, 0, 32'h88));
        expect_tok("d0 end", tok(KEnd, 0, 0, 0));

        // Full stack, same id at every level.
        send(mk_path(6, 6, 6, 6), 3'd4, 16'd5, 32'h5, 1'b0);
        expect_tok("f open L0", tok(KOpen, 6, 0, 0));
        expect_tok("f open L1", tok(KOpen, 6, 1, 0));
        expect_tok("f open L2", tok(KOpen, 6, 2, 0));
        expect_tok("f open L3", tok(KOpen, 6, 3, 0));
        expect_tok("f leaf5", tok(KLeaf, 5, 4, 32'h5));
        check("f cur_depth", {61'b0, cur_depth}, 64'd4);
        send(mk_path(6, 6, 6, 0), 3'd3, 16'd1, 32'h1, 1'b1);
        expect_tok("f close L3", tok(KClose, 6, 3, 0));
        expect_tok("f leaf1", tok(KLeaf, 1, 3, 32'h1));
        expect_tok("f close L2", tok(KClose, 6, 2, 0));
        expect_tok("f close L1", tok(KClose, 6, 1, 0));
        expect_tok("f close L0", tok(KClose, 6, 0, 0));
        expect_tok("f end", tok(KEnd, 0, 0, 0));
        check("f cur_depth end", {61'b0, cur_depth}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
